// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM pad-block initiator: FSM state encoding and default widths.
package sram_controller_pkg;

  localparam int unsigned ADDR_BITS_DEF    = 20;
  localparam int unsigned DATA_BITS_DEF    = 16;
  localparam int unsigned READ_LATENCY_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

  // True when a request would reverse the bus direction of the current streaming state.
  function automatic logic dir_conflict(input state_e st, input logic wr);
    return ((st == ST_READ) && wr) || ((st == ST_WRITE) && !wr);
  endfunction

endpackage

// File: rtl/sram_rd_track.sv
// Valid+address delay line that lines up each issued read with the pad block's data return.
module sram_rd_track #(
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned ADDR_BITS    = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_valid,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 o_valid,
  output logic [ADDR_BITS-1:0] o_addr
);

  logic [READ_LATENCY-1:0] r_valid;
  logic [ADDR_BITS-1:0]    r_addr [READ_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_addr[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  assign o_valid = r_valid[READ_LATENCY-1];
  assign o_addr  = r_addr[READ_LATENCY-1];

endmodule

// File: rtl/sram_controller.sv
// Request-stream to iCE40 SRAM pad-block initiator: registered strobes, read/write turnaround,
// and read-return tracking.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_unexpected,
  output logic [ADDR_BITS-1:0] pad_addr,
  output logic [DATA_BITS-1:0] pad_write_data,
  output logic                 pad_write_data_enable,
  output logic                 pad_ce_n,
  output logic                 pad_we_n,
  output logic                 pad_oe_n,
  input  logic [DATA_BITS-1:0] pad_read_data,
  input  logic                 pad_read_data_valid,
  output state_e               dbg_state
);

  state_e               r_state;
  logic                 r_pad_ce_n;
  logic                 r_pad_we_n;
  logic                 r_pad_oe_n;
  logic                 r_pad_wde;
  logic [ADDR_BITS-1:0] r_pad_addr;
  logic [DATA_BITS-1:0] r_pad_wdata;
  logic                 r_rd_valid;
  logic [DATA_BITS-1:0] r_rd_data;
  logic [ADDR_BITS-1:0] r_rd_addr;
  logic                 r_rd_unexpected;

  logic                 w_conflict;
  logic                 w_accept;
  logic                 w_trk_valid;
  logic [ADDR_BITS-1:0] w_trk_addr;

  // Handshake: a request transfers on a posedge where req_valid && req_ready. req_ready
  // looks only at the FSM state and the offered direction, never at the read-return path.
  assign w_conflict = req_valid && dir_conflict(r_state, req_write);
  assign req_ready  = (r_state != ST_TURN) && !w_conflict;
  assign w_accept   = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pad_ce_n  <= 1'b1;
      r_pad_we_n  <= 1'b1;
      r_pad_oe_n  <= 1'b1;
      r_pad_wde   <= 1'b0;
      r_pad_addr  <= '0;
      r_pad_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= req_write ? ST_WRITE : ST_READ;
        end
        ST_READ, ST_WRITE: begin
          if (w_conflict)    r_state <= ST_TURN;
          else if (!w_accept) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        r_pad_ce_n <= 1'b0;
        r_pad_we_n <= !req_write;
        r_pad_oe_n <= req_write;
        r_pad_wde  <= req_write;
        r_pad_addr <= req_addr;
        if (req_write) r_pad_wdata <= req_wdata;
      end else begin
        r_pad_ce_n <= 1'b1;
        r_pad_we_n <= 1'b1;
        r_pad_oe_n <= 1'b1;
        r_pad_wde  <= 1'b0;
      end
    end
  end

  // The pad block samples oe_n on the same edge that loads the tracker.
  sram_rd_track #(
    .READ_LATENCY (READ_LATENCY),
    .ADDR_BITS    (ADDR_BITS)
  ) u_rd_track (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (!r_pad_oe_n),
    .i_addr  (r_pad_addr),
    .o_valid (w_trk_valid),
    .o_addr  (w_trk_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid      <= 1'b0;
      r_rd_data       <= '0;
      r_rd_addr       <= '0;
      r_rd_unexpected <= 1'b0;
    end else begin
      r_rd_valid <= pad_read_data_valid && w_trk_valid;
      if (pad_read_data_valid && w_trk_valid) begin
        r_rd_data <= pad_read_data;
        r_rd_addr <= w_trk_addr;
      end
      if (pad_read_data_valid && !w_trk_valid) r_rd_unexpected <= 1'b1;
    end
  end

  assign pad_ce_n              = r_pad_ce_n;
  assign pad_we_n              = r_pad_we_n;
  assign pad_oe_n              = r_pad_oe_n;
  assign pad_write_data_enable = r_pad_wde;
  assign pad_addr              = r_pad_addr;
  assign pad_write_data        = r_pad_wdata;
  assign rd_valid              = r_rd_valid;
  assign rd_data               = r_rd_data;
  assign rd_addr               = r_rd_addr;
  assign rd_unexpected         = r_rd_unexpected;
  assign dbg_state             = r_state;

endmodule
